// File: rtl/dc_mem_bridge.sv
// Data-cache line bridge: queues LSU line reads/writes in order and issues them one at a time
// on a 128-bit memory command interface. Define DC_MEM_BRIDGE_PERF_EN to add perf counters.
module dc_mem_bridge #(
    parameter int unsigned QAW = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dcw_start_rq,
    input  logic [31:0]  dcw_in_addr,
    input  logic [15:0]  dcw_in_mask,
    input  logic [127:0] dcw_in_data,
    output logic         dcw_finish_wresp,
    input  logic         dcr_start_rq,
    input  logic [31:0]  dcr_rin_addr,
    input  logic         rqfull_1,
    output logic [127:0] rdat_m_data,
    output logic         rdat_m_valid,
    output logic         finish_mrd,
    output logic         bridge_busy,
    output logic         q_almost_full,
    output logic         ovf_err,
    output logic         mem_cmd_valid,
    input  logic         mem_cmd_ready,
    output logic         mem_cmd_we,
    output logic [27:0]  mem_addr,
    output logic [15:0]  mem_wmask,
    output logic [127:0] mem_wdata,
    input  logic         mem_wresp_valid,
    input  logic         mem_rdata_valid,
`ifdef DC_MEM_BRIDGE_PERF_EN
    output logic [31:0]  perf_wr_cnt,
    output logic [31:0]  perf_rd_cnt,
    output logic [31:0]  perf_wait_cnt,
`endif
    input  logic [127:0] mem_rdata
);

    localparam int unsigned Depth  = 1 << QAW;
    localparam int unsigned EntryW = 1 + 28 + 16 + 128;
    localparam logic [QAW:0] QDepth = {1'b1, {QAW{1'b0}}};

    typedef enum logic [1:0] {StIdle, StIssue, StWaitWr, StWaitRd} state_e;

    state_e              state_q, state_d;
    logic [EntryW-1:0]   fifo_q [Depth];
    logic [QAW:0]        count_q, count_d, count_after_pop;
    logic [QAW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_slot;
    logic                pop, push_w, push_r;
    logic [EntryW-1:0]   w_entry, r_entry, head;
    logic                ovf_q, ovf_d;
    logic                cmd_we_q, cmd_we_d;
    logic [27:0]         cmd_addr_q, cmd_addr_d;
    logic [15:0]         cmd_mask_q, cmd_mask_d;
    logic [127:0]        cmd_data_q, cmd_data_d;
    logic                wfin_q, wfin_d;
    logic                rvalid_q, rvalid_d;
    logic [127:0]        rdat_q, rdat_d;

    // Sub-line address bits and the core's queue-full hint carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{rqfull_1, dcw_in_addr[3:0], dcr_rin_addr[3:0]};

    assign w_entry = {1'b1, dcw_in_addr[31:4], dcw_in_mask, dcw_in_data};
    assign r_entry = {1'b0, dcr_rin_addr[31:4], 16'h0000, 128'h0};
    assign head    = fifo_q[rd_ptr_q];

    // Queue bookkeeping: a same-edge pop frees its slot, the write is pushed before the read.
    always_comb begin
        pop             = (state_q == StIdle) && (count_q != '0);
        count_after_pop = count_q - (QAW+1)'(pop);
        push_w          = dcw_start_rq && (count_after_pop != QDepth);
        push_r          = dcr_start_rq && ((count_after_pop + (QAW+1)'(push_w)) != QDepth);
        count_d         = count_after_pop + (QAW+1)'(push_w) + (QAW+1)'(push_r);
        wr_ptr_d        = wr_ptr_q + QAW'(push_w) + QAW'(push_r);
        rd_ptr_d        = rd_ptr_q + QAW'(pop);
        rd_slot         = push_w ? (wr_ptr_q + QAW'(1)) : wr_ptr_q;
        ovf_d           = ovf_q | (dcw_start_rq & ~push_w) | (dcr_start_rq & ~push_r);
    end

    always_ff @(posedge clk) begin
        if (push_w) fifo_q[wr_ptr_q] <= w_entry;
        if (push_r) fifo_q[rd_slot] <= r_entry;
    end

    always_comb begin
        state_d    = state_q;
        cmd_we_d   = cmd_we_q;
        cmd_addr_d = cmd_addr_q;
        cmd_mask_d = cmd_mask_q;
        cmd_data_d = cmd_data_q;
        wfin_d     = 1'b0;
        rvalid_d   = 1'b0;
        rdat_d     = rdat_q;
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = StIssue;
                    {cmd_we_d, cmd_addr_d, cmd_mask_d, cmd_data_d} = head;
                end
            end
            StIssue: begin
                if (mem_cmd_ready) state_d = cmd_we_q ? StWaitWr : StWaitRd;
            end
            StWaitWr: begin
                if (mem_wresp_valid) begin
                    wfin_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StWaitRd: begin
                if (mem_rdata_valid) begin
                    rvalid_d = 1'b1;
                    rdat_d   = mem_rdata;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            cmd_we_q   <= 1'b0;
            cmd_addr_q <= '0;
            cmd_mask_q <= '0;
            cmd_data_q <= '0;
            wfin_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            rdat_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            cmd_we_q   <= cmd_we_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_mask_q <= cmd_mask_d;
            cmd_data_q <= cmd_data_d;
            wfin_q     <= wfin_d;
            rvalid_q   <= rvalid_d;
            rdat_q     <= rdat_d;
        end
    end

    assign dcw_finish_wresp = wfin_q;
    assign rdat_m_valid     = rvalid_q;
    assign finish_mrd       = rvalid_q;
    assign rdat_m_data      = rdat_q;
    assign ovf_err          = ovf_q;
    assign bridge_busy      = (count_q != '0) || (state_q != StIdle);
    assign q_almost_full    = (QDepth - count_q) < (QAW+1)'(2);
    assign mem_cmd_valid    = (state_q == StIssue);
    assign mem_cmd_we       = cmd_we_q;
    assign mem_addr         = cmd_addr_q;
    assign mem_wmask        = cmd_mask_q;
    assign mem_wdata        = cmd_data_q;

`ifdef DC_MEM_BRIDGE_PERF_EN
    logic [31:0] perf_wr_q, perf_wr_d, perf_rd_q, perf_rd_d, perf_wait_q, perf_wait_d;

    always_comb begin
        perf_wr_d   = perf_wr_q;
        perf_rd_d   = perf_rd_q;
        perf_wait_d = perf_wait_q;
        if (wfin_q && (perf_wr_q != '1)) perf_wr_d = perf_wr_q + 32'd1;
        if (rvalid_q && (perf_rd_q != '1)) perf_rd_d = perf_rd_q + 32'd1;
        if ((state_q == StIssue) && !mem_cmd_ready && (perf_wait_q != '1)) begin
            perf_wait_d = perf_wait_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_wr_q   <= '0;
            perf_rd_q   <= '0;
            perf_wait_q <= '0;
        end else begin
            perf_wr_q   <= perf_wr_d;
            perf_rd_q   <= perf_rd_d;
            perf_wait_q <= perf_wait_d;
        end
    end

    assign perf_wr_cnt   = perf_wr_q;
    assign perf_rd_cnt   = perf_rd_q;
    assign perf_wait_cnt = perf_wait_q;
`endif

endmodule

// File: tb/tb_dc_mem_bridge.sv
// Directed bench for dc_mem_bridge: queue-level reference model checked every cycle, plus
// literal expectations from hand-worked scenarios. Perf checks run when DC_MEM_BRIDGE_PERF_EN is set.
module tb_dc_mem_bridge;

    localparam int QAW   = 2;
    localparam int DEPTH = 1 << QAW;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         dcw_start_rq = 1'b0;
    logic [31:0]  dcw_in_addr = '0;
    logic [15:0]  dcw_in_mask = '0;
    logic [127:0] dcw_in_data = '0;
    logic         dcw_finish_wresp;
    logic         dcr_start_rq = 1'b0;
    logic [31:0]  dcr_rin_addr = '0;
    logic         rqfull_1 = 1'b0;
    logic [127:0] rdat_m_data;
    logic         rdat_m_valid, finish_mrd, bridge_busy, q_almost_full, ovf_err;
    logic         mem_cmd_valid;
    logic         mem_cmd_ready = 1'b0;
    logic         mem_cmd_we;
    logic [27:0]  mem_addr;
    logic [15:0]  mem_wmask;
    logic [127:0] mem_wdata;
    logic         mem_wresp_valid = 1'b0;
    logic         mem_rdata_valid = 1'b0;
    logic [127:0] mem_rdata = '0;
`ifdef DC_MEM_BRIDGE_PERF_EN
    logic [31:0]  perf_wr_cnt, perf_rd_cnt, perf_wait_cnt;
`endif

    dc_mem_bridge #(.QAW(QAW)) dut (
        .clk(clk), .rst(rst),
        .dcw_start_rq(dcw_start_rq), .dcw_in_addr(dcw_in_addr), .dcw_in_mask(dcw_in_mask),
        .dcw_in_data(dcw_in_data), .dcw_finish_wresp(dcw_finish_wresp),
        .dcr_start_rq(dcr_start_rq), .dcr_rin_addr(dcr_rin_addr), .rqfull_1(rqfull_1),
        .rdat_m_data(rdat_m_data), .rdat_m_valid(rdat_m_valid), .finish_mrd(finish_mrd),
        .bridge_busy(bridge_busy), .q_almost_full(q_almost_full), .ovf_err(ovf_err),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
        .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_wresp_valid(mem_wresp_valid), .mem_rdata_valid(mem_rdata_valid),
`ifdef DC_MEM_BRIDGE_PERF_EN
        .perf_wr_cnt(perf_wr_cnt), .perf_rd_cnt(perf_rd_cnt), .perf_wait_cnt(perf_wait_cnt),
`endif
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference model: a request list plus the one in-flight request and its phase.
    typedef struct packed {
        logic         we;
        logic [27:0]  addr;
        logic [15:0]  mask;
        logic [127:0] data;
    } req_t;

    req_t         mq[$];
    req_t         m_cur;
    int           m_ph = 0;     // 0 idle, 1 issuing, 2 awaiting write resp, 3 awaiting read data
    bit           m_live = 0;
    logic         m_wfin = 0, m_rfin = 0, m_ovf = 0;
    logic [127:0] m_rdat = '0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_cur = '0; m_ph = 0; m_wfin = 0; m_rfin = 0; m_ovf = 0; m_rdat = '0;
            m_live = 1;
        end else if (m_live) begin
            m_wfin = 0;
            m_rfin = 0;
            case (m_ph)
                0: if (mq.size() > 0) begin m_cur = mq.pop_front(); m_ph = 1; end
                1: if (mem_cmd_ready) m_ph = m_cur.we ? 2 : 3;
                2: if (mem_wresp_valid) begin m_wfin = 1; m_ph = 0; end
                3: if (mem_rdata_valid) begin m_rfin = 1; m_rdat = mem_rdata; m_ph = 0; end
                default: m_ph = 0;
            endcase
            if (dcw_start_rq) begin
                if (mq.size() < DEPTH)
                    mq.push_back('{1'b1, dcw_in_addr[31:4], dcw_in_mask, dcw_in_data});
                else m_ovf = 1;
            end
            if (dcr_start_rq) begin
                if (mq.size() < DEPTH) mq.push_back('{1'b0, dcr_rin_addr[31:4], 16'h0, 128'h0});
                else m_ovf = 1;
            end
        end
    end

    int   n_wfin = 0, n_rfin = 0, n_cmd = 0;
    logic prev_valid = 0;

    always @(negedge clk) begin
        if (m_live) begin
            chk("cmd_valid", mem_cmd_valid, m_ph == 1);
            if (m_ph == 1) begin
                chk("cmd_we", mem_cmd_we, m_cur.we);
                chk("cmd_addr", mem_addr, m_cur.addr);
                if (m_cur.we) begin
                    chk("cmd_mask", mem_wmask, m_cur.mask);
                    chk("cmd_data", mem_wdata, m_cur.data);
                end
            end
            chk("wresp_pulse", dcw_finish_wresp, m_wfin);
            chk("rdat_valid", rdat_m_valid, m_rfin);
            chk("finish_mrd", finish_mrd, m_rfin);
            chk("rdat_data", rdat_m_data, m_rdat);
            chk("busy", bridge_busy, (mq.size() > 0) || (m_ph != 0));
            chk("almost_full", q_almost_full, (DEPTH - mq.size()) < 2);
            chk("ovf_err", ovf_err, m_ovf);
        end
        if (dcw_finish_wresp === 1'b1) n_wfin++;
        if (finish_mrd === 1'b1) n_rfin++;
        if (mem_cmd_valid === 1'b1 && !prev_valid) n_cmd++;
        prev_valid = (mem_cmd_valid === 1'b1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Wait for the next command, check it, accept it after `hold` stalled cycles, then respond.
    task automatic serve(input string nm, input logic we, input logic [27:0] addr,
                         input logic [127:0] rd, input int hold);
        int n;
        n = 0;
        @(negedge clk);
        while (mem_cmd_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, mem_cmd_valid, 1'b1);
        chk({nm, "_we"}, mem_cmd_we, we);
        chk({nm, "_addr"}, mem_addr, addr);
        repeat (hold) @(negedge clk);
        mem_cmd_ready = 1'b1;
        cyc();
        mem_cmd_ready = 1'b0;
        if (we) mem_wresp_valid = 1'b1;
        else begin
            mem_rdata_valid = 1'b1;
            mem_rdata = rd;
        end
        cyc();
        mem_wresp_valid = 1'b0;
        mem_rdata_valid = 1'b0;
        @(negedge clk);
        if (we) chk({nm, "_wfin"}, dcw_finish_wresp, 1'b1);
        else begin
            chk({nm, "_rvalid"}, rdat_m_valid, 1'b1);
            chk({nm, "_rdata"}, rdat_m_data, rd);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int b_w, b_r, b_c;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", mem_cmd_valid, 1'b0);
        chk("rst_busy", bridge_busy, 1'b0);
        chk("rst_afull", q_almost_full, 1'b0);
        chk("rst_rdat", rdat_m_data, 128'h0);
        cyc();

        // Single read with hand-counted latency.
        dcr_start_rq = 1'b1; dcr_rin_addr = 32'h0000_1230;
        cyc();
        dcr_start_rq = 1'b0;
        cyc();
        mem_cmd_ready = 1'b1;
        @(negedge clk);
        chk("rd_c2_valid", mem_cmd_valid, 1'b1);
        chk("rd_c2_we", mem_cmd_we, 1'b0);
        chk("rd_c2_addr", mem_addr, 28'h000_0123);
        cyc();
        mem_cmd_ready = 1'b0;
        cyc();
        cyc();
        mem_rdata_valid = 1'b1; mem_rdata = 128'hDEADBEEF_0000_0000_0000_0000_0000_0001;
        cyc();
        mem_rdata_valid = 1'b0;
        @(negedge clk);
        chk("rd_c6_valid", rdat_m_valid, 1'b1);
        chk("rd_c6_finish", finish_mrd, 1'b1);
        chk("rd_c6_data", rdat_m_data, 128'hDEADBEEF_0000_0000_0000_0000_0000_0001);
        cyc();

        // Single write held off by three stalled cycles.
        dcw_start_rq = 1'b1; dcw_in_addr = 32'h8000_0010; dcw_in_mask = 16'h00FF;
        dcw_in_data = {16{8'hA5}};
        cyc();
        dcw_start_rq = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wr_stall_valid", mem_cmd_valid, 1'b1);
            chk("wr_stall_addr", mem_addr, 28'h800_0001);
            chk("wr_stall_mask", mem_wmask, 16'h00FF);
            chk("wr_stall_data", mem_wdata, {16{8'hA5}});
            cyc();
        end
        mem_cmd_ready = 1'b1;
        cyc();
        mem_cmd_ready = 1'b0; mem_wresp_valid = 1'b1;
        cyc();
        mem_wresp_valid = 1'b0;
        @(negedge clk);
        chk("wr_fin", dcw_finish_wresp, 1'b1);
        cyc();
        @(negedge clk);
        chk("wr_fin_once", dcw_finish_wresp, 1'b0);
        cyc();

        // Simultaneous write and read: write goes first.
        b_w = n_wfin; b_r = n_rfin;
        dcw_start_rq = 1'b1; dcw_in_addr = 32'h0000_0100; dcw_in_mask = 16'hF00F;
        dcw_in_data = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        dcr_start_rq = 1'b1; dcr_rin_addr = 32'h0000_0200;
        cyc();
        dcw_start_rq = 1'b0; dcr_start_rq = 1'b0;
        serve("sim_w", 1'b1, 28'h000_0010, '0, 0);
        serve("sim_r", 1'b0, 28'h000_0020, 128'hCAFE_0000_0000_0000_0000_0000_0000_BABE, 0);
        repeat (3) cyc();
        chk("sim_wfin_cnt", n_wfin - b_w, 1);
        chk("sim_rfin_cnt", n_rfin - b_r, 1);

        // Fill with ready low: one request held in ISSUE, four queued, the sixth dropped.
        b_c = n_cmd;
        rqfull_1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dcr_start_rq = 1'b1; dcr_rin_addr = (i + 1) << 12;
            @(negedge clk);
            if (i == 3) chk("fill_afull_2q", q_almost_full, 1'b0);
            if (i == 4) chk("fill_afull_3q", q_almost_full, 1'b1);
            if (i == 5) chk("fill_no_ovf_yet", ovf_err, 1'b0);
            cyc();
        end
        dcr_start_rq = 1'b0; rqfull_1 = 1'b0;
        @(negedge clk);
        chk("fill_ovf", ovf_err, 1'b1);
        chk("fill_busy", bridge_busy, 1'b1);
        for (int k = 0; k < 5; k++) begin
            serve("fill", 1'b0, 28'(32'h100 * (k + 1)), 128'(k + 16), 0);
        end
        repeat (10) cyc();
        @(negedge clk);
        chk("fill_cmd_cnt", n_cmd - b_c, 5);
        chk("fill_idle", bridge_busy, 1'b0);
        chk("fill_ovf_sticky", ovf_err, 1'b1);
        cyc();

        // Reset while awaiting read data; the late response must be ignored.
        b_r = n_rfin;
        dcr_start_rq = 1'b1; dcr_rin_addr = 32'h0000_3000;
        cyc();
        dcr_start_rq = 1'b0;
        cyc();
        mem_cmd_ready = 1'b1;
        cyc();
        mem_cmd_ready = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mem_rdata_valid = 1'b1; mem_rdata = 128'h5555;
        cyc();
        mem_rdata_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_rd_valid", rdat_m_valid, 1'b0);
            chk("rst_rd_data", rdat_m_data, 128'h0);
            chk("rst_rd_busy", bridge_busy, 1'b0);
            chk("rst_rd_ovf", ovf_err, 1'b0);
            cyc();
        end
        chk("rst_rd_fin_cnt", n_rfin - b_r, 0);

`ifdef DC_MEM_BRIDGE_PERF_EN
        dcw_start_rq = 1'b1; dcw_in_addr = 32'h0000_0400; dcr_start_rq = 1'b1;
        dcr_rin_addr = 32'h0000_0500;
        cyc();
        dcr_start_rq = 1'b0; dcw_in_addr = 32'h0000_0600;
        cyc();
        dcw_start_rq = 1'b0;
        serve("perf_w0", 1'b1, 28'h000_0040, '0, 2);
        serve("perf_r", 1'b0, 28'h000_0050, 128'h77, 1);
        serve("perf_w1", 1'b1, 28'h000_0060, '0, 1);
        repeat (2) cyc();
        chk("perf_wr", perf_wr_cnt, 32'd2);
        chk("perf_rd", perf_rd_cnt, 32'd1);
        chk("perf_wait", perf_wait_cnt, 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
